// File: rtl/uart_fifo_pkg.sv
// Shared constants and types for the UART TX/RX FIFOs.
package uart_fifo_pkg;

    localparam int UART_DATA_W_DEF     = 8;
    localparam int UART_FIFO_DEPTH_DEF = 16;
    localparam int UART_LEVEL_W_DEF    = $clog2(UART_FIFO_DEPTH_DEF) + 1;

    // Occupancy count 0..DEPTH for the default-depth FIFOs
    typedef logic [UART_LEVEL_W_DEF-1:0] fifo_level_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// 1W1R register array with a registered (synchronous) read port.
module uart_fifo_ram
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W_DEF,
    parameter int DEPTH  = UART_FIFO_DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage write; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register holds the last popped word until the next read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= {DATA_W{1'b0}};
        end else if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter, with registered status flags.
// Optional sticky overflow/underflow outputs are enabled by defining UART_TX_FIFO_ERR_EN.
module uart_tx_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W    = UART_DATA_W_DEF,
    parameter int DEPTH     = UART_FIFO_DEPTH_DEF,
    parameter int AF_THRESH = 12,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk_fifo_tx,
    input  logic              rst_n_fifo_tx,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              next_frame,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   level
`ifdef UART_TX_FIFO_ERR_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam int              LVL_W     = ADDR_W + 1;
    localparam logic [ADDR_W:0] ONE_LVL   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] DEPTH_LVL = LVL_W'(DEPTH);
    localparam logic [ADDR_W:0] AF_LVL    = LVL_W'(AF_THRESH);

    logic [ADDR_W:0] wr_ptr_r;
    logic [ADDR_W:0] rd_ptr_r;
    logic [ADDR_W:0] level_nxt_s;
    logic            rd_acc_s;
    logic            wr_acc_s;

    // Request acceptance and next occupancy; a pop frees the slot a full-FIFO write needs
    always_comb begin
        rd_acc_s = next_frame & ~empty;
        wr_acc_s = wr_en & (~full | rd_acc_s);
        case ({wr_acc_s, rd_acc_s})
            2'b10:   level_nxt_s = level + ONE_LVL;
            2'b01:   level_nxt_s = level - ONE_LVL;
            default: level_nxt_s = level;
        endcase
    end

    // Pointers, occupancy, flags and pop strobe
    always_ff @(posedge clk_fifo_tx or negedge rst_n_fifo_tx) begin
        if (!rst_n_fifo_tx) begin
            wr_ptr_r    <= {LVL_W{1'b0}};
            rd_ptr_r    <= {LVL_W{1'b0}};
            level       <= {LVL_W{1'b0}};
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
            data_valid  <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_LVL;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_LVL;
            end
            level       <= level_nxt_s;
            full        <= (level_nxt_s == DEPTH_LVL);
            empty       <= (level_nxt_s == {LVL_W{1'b0}});
            almost_full <= (level_nxt_s >= AF_LVL);
            data_valid  <= rd_acc_s;
        end
    end

    uart_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk_fifo_tx),
        .rst_n   (rst_n_fifo_tx),
        .wr_en   (wr_acc_s),
        .wr_addr (wr_ptr_r[ADDR_W-1:0]),
        .wr_data (data_in),
        .rd_en   (rd_acc_s),
        .rd_addr (rd_ptr_r[ADDR_W-1:0]),
        .rd_data (data_out)
    );

`ifdef UART_TX_FIFO_ERR_EN
    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk_fifo_tx or negedge rst_n_fifo_tx) begin
        if (!rst_n_fifo_tx) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow | (wr_en & full & ~rd_acc_s);
            underflow <= underflow | (next_frame & empty);
        end
    end
`else
    // Without the error option, rejected requests leave no trace
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized and directed checks of uart_tx_fifo against a queue-based reference model.
// Two instances: default 8x16, and a 5x4 instance exercising pointer wrap.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       we_a = 1'b0, nf_a = 1'b0;
    logic [7:0] din_a = 8'h00;
    logic [7:0] dout_a;
    logic       dv_a, full_a, empty_a, af_a;
    logic [4:0] level_a;

    logic       we_b = 1'b0, nf_b = 1'b0;
    logic [4:0] din_b = 5'h00;
    logic [4:0] dout_b;
    logic       dv_b, full_b, empty_b, af_b;
    logic [2:0] level_b;

`ifdef UART_TX_FIFO_ERR_EN
    logic ovf_a, unf_a, ovf_b, unf_b;
    logic eov_a = 1'b0, eun_a = 1'b0, eov_b = 1'b0, eun_b = 1'b0;
`endif

    logic [7:0] qa [$];
    logic [4:0] qb [$];
    logic [7:0] ed_a = 8'h00;
    logic [4:0] ed_b = 5'h00;
    logic       ev_a = 1'b0, ev_b = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_fifo dut_a (
        .clk_fifo_tx   (clk),
        .rst_n_fifo_tx (rst_n),
        .wr_en         (we_a),
        .data_in       (din_a),
        .next_frame    (nf_a),
        .data_out      (dout_a),
        .data_valid    (dv_a),
        .full          (full_a),
        .empty         (empty_a),
        .almost_full   (af_a),
        .level         (level_a)
`ifdef UART_TX_FIFO_ERR_EN
        ,
        .overflow      (ovf_a),
        .underflow     (unf_a)
`endif
    );

    uart_tx_fifo #(.DATA_W(5), .DEPTH(4), .AF_THRESH(3)) dut_b (
        .clk_fifo_tx   (clk),
        .rst_n_fifo_tx (rst_n),
        .wr_en         (we_b),
        .data_in       (din_b),
        .next_frame    (nf_b),
        .data_out      (dout_b),
        .data_valid    (dv_b),
        .full          (full_b),
        .empty         (empty_b),
        .almost_full   (af_b),
        .level         (level_b)
`ifdef UART_TX_FIFO_ERR_EN
        ,
        .overflow      (ovf_b),
        .underflow     (unf_b)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check_eq("dout_a",  dout_a,  ed_a);
        check_eq("dv_a",    dv_a,    ev_a);
        check_eq("level_a", level_a, qa.size());
        check_eq("full_a",  full_a,  qa.size() == 16);
        check_eq("empty_a", empty_a, qa.size() == 0);
        check_eq("af_a",    af_a,    qa.size() >= 12);
        check_eq("dout_b",  dout_b,  ed_b);
        check_eq("dv_b",    dv_b,    ev_b);
        check_eq("level_b", level_b, qb.size());
        check_eq("full_b",  full_b,  qb.size() == 4);
        check_eq("empty_b", empty_b, qb.size() == 0);
        check_eq("af_b",    af_b,    qb.size() >= 3);
`ifdef UART_TX_FIFO_ERR_EN
        check_eq("ovf_a", ovf_a, eov_a);
        check_eq("unf_a", unf_a, eun_a);
        check_eq("ovf_b", ovf_b, eov_b);
        check_eq("unf_b", unf_b, eun_b);
`endif
    endtask

    // One clock: update the model from the inputs seen at the edge, then compare
    task automatic step();
        int  sa, sb;
        logic rda, wra, rdb, wrb;
        @(posedge clk);
        sa  = qa.size();
        rda = nf_a && (sa > 0);
        wra = we_a && ((sa < 16) || rda);
`ifdef UART_TX_FIFO_ERR_EN
        if (we_a && sa == 16 && !rda) eov_a = 1'b1;
        if (nf_a && sa == 0) eun_a = 1'b1;
`endif
        ev_a = rda;
        if (rda) ed_a = qa.pop_front();
        if (wra) qa.push_back(din_a);

        sb  = qb.size();
        rdb = nf_b && (sb > 0);
        wrb = we_b && ((sb < 4) || rdb);
`ifdef UART_TX_FIFO_ERR_EN
        if (we_b && sb == 4 && !rdb) eov_b = 1'b1;
        if (nf_b && sb == 0) eun_b = 1'b1;
`endif
        ev_b = rdb;
        if (rdb) ed_b = qb.pop_front();
        if (wrb) qb.push_back(din_b);
        #1;
        compare_all();
    endtask

    task automatic idle();
        we_a = 1'b0; nf_a = 1'b0;
        we_b = 1'b0; nf_b = 1'b0;
    endtask

    // Asynchronous reset between edges; outputs must clear without waiting for a clock
    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        ed_a = 8'h00; ev_a = 1'b0;
        ed_b = 5'h00; ev_b = 1'b0;
`ifdef UART_TX_FIFO_ERR_EN
        eov_a = 1'b0; eun_a = 1'b0; eov_b = 1'b0; eun_b = 1'b0;
`endif
        #1;
        compare_all();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check_eq("rst_empty", empty_a, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill 0x11..0x20
        for (int i = 0; i < 16; i++) begin
            we_a = 1'b1;
            din_a = 8'h11 + 8'(i);
            step();
        end
        idle();
        check_eq("fill_full", full_a, 1'b1);
        check_eq("fill_lvl",  level_a, 5'd16);

        // Drain with next_frame held
        nf_a = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            check_eq("drain_word", dout_a, 8'h11 + 8'(i));
            check_eq("drain_dv",   dv_a, 1'b1);
        end
        nf_a = 1'b0;
        step();
        check_eq("drain_empty", empty_a, 1'b1);
        check_eq("drain_dv_end", dv_a, 1'b0);

        // Write at full with a simultaneous pop
        for (int i = 0; i < 16; i++) begin
            we_a = 1'b1;
            din_a = 8'($urandom);
            step();
        end
        we_a = 1'b1; nf_a = 1'b1; din_a = 8'hAB;
        step();
        check_eq("fullpop_lvl", level_a, 5'd16);
        we_a = 1'b0;
        for (int i = 0; i < 16; i++) step();
        check_eq("fullpop_last", dout_a, 8'hAB);
        nf_a = 1'b0;
        step();

        // Write and pop together on empty: only the write lands
        we_a = 1'b1; nf_a = 1'b1; din_a = 8'h5C;
        step();
        check_eq("emptywp_lvl", level_a, 5'd1);
        check_eq("emptywp_dv",  dv_a, 1'b0);
        we_a = 1'b0;
        step();
        check_eq("emptywp_pop", dout_a, 8'h5C);
        check_eq("emptywp_dv2", dv_a, 1'b1);
        idle();
        step();

        // Random mixed traffic; the small instance wraps its pointers many times
        for (int i = 0; i < 300; i++) begin
            if (i < 150) begin
                we_a = ($urandom_range(0, 3) != 0);
                nf_a = ($urandom_range(0, 3) == 0);
            end else begin
                we_a = ($urandom_range(0, 3) == 0);
                nf_a = ($urandom_range(0, 3) != 0);
            end
            din_a = 8'($urandom);
            we_b  = ($urandom_range(0, 1) == 1);
            nf_b  = ($urandom_range(0, 1) == 1);
            din_b = 5'($urandom);
            step();
            check_eq("b_lvl_max", level_b <= 3'd4, 1'b1);
        end
        idle();
        step();

        // Reset mid-stream at level 7 with pops active
        do_reset();
        for (int i = 0; i < 7; i++) begin
            we_a = 1'b1;
            din_a = 8'($urandom);
            we_b = 1'b1; nf_b = 1'b1;
            din_b = 5'($urandom);
            step();
        end
        we_a = 1'b1; nf_a = 1'b1; din_a = 8'h77;
        step();
        check_eq("pre_rst_lvl", level_a, 5'd7);
        do_reset();
        check_eq("post_rst_lvl", level_a, 5'd0);
        check_eq("post_rst_dv",  dv_a, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
